// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the pipeline hazard scoreboard: forwarding encodings,
// tracking-slot indices and the per-slot state record.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int SLOT_EX    = 0;
  localparam int SLOT_MEM   = 1;
  localparam int SLOT_WB    = 2;
  localparam int SLOT_COUNT = 3;

  // Register indices are stored zero-extended to this width so one struct serves
  // every REG_INDEX_WIDTH up to 8.
  localparam int MAX_REG_INDEX_WIDTH = 8;

  typedef struct packed {
    logic                           valid;
    logic                           regWrite;
    logic                           memRead;
    logic [MAX_REG_INDEX_WIDTH-1:0] writeIndex;
  } slotStateT;

  // Register 0 is hardwired, so no slot ever counts as writing it.
  function automatic logic slotWrites(input slotStateT slot,
                                      input logic [MAX_REG_INDEX_WIDTH-1:0] index);
    return slot.valid && slot.regWrite && (slot.writeIndex == index) && (index != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue bus between the decode stage and the hazard scoreboard,
// carrying the stall and EX forwarding selects back to the pipeline.
interface hazard_scoreboard_if #(
  parameter int REG_INDEX_WIDTH = 5,
  parameter int NUM_SOURCES     = 2
);

  logic                                   issueValid;
  logic [REG_INDEX_WIDTH-1:0]             issueWriteIndex;
  logic                                   issueRegWrite;
  logic                                   issueMemRead;
  logic [NUM_SOURCES*REG_INDEX_WIDTH-1:0] issueSourceIndex;
  logic [NUM_SOURCES-1:0]                 issueSourceUsed;
  logic                                   flush;
  logic                                   stall;
  logic [NUM_SOURCES*2-1:0]               forwardSelect;

  modport master (
    output issueValid, issueWriteIndex, issueRegWrite, issueMemRead,
           issueSourceIndex, issueSourceUsed, flush,
    input  stall, forwardSelect
  );

  modport slave (
    input  issueValid, issueWriteIndex, issueRegWrite, issueMemRead,
           issueSourceIndex, issueSourceUsed, flush,
    output stall, forwardSelect
  );

endinterface

// File: rtl/hazard_source_match.sv
// Compares one source register index against the EX/MEM/WB tracking slots and
// reports which slots write it, and which of those are loads.
module hazard_source_match
  import hazard_scoreboard_pkg::*;
(
  input  logic [MAX_REG_INDEX_WIDTH-1:0] sourceIndex,
  input  slotStateT [SLOT_COUNT-1:0]     slots,
  output logic [SLOT_COUNT-1:0]          slotMatch,
  output logic [SLOT_COUNT-1:0]          slotLoadMatch
);

  always_comb begin
    slotMatch     = '0;
    slotLoadMatch = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      slotMatch[i]     = slotWrites(slots[i], sourceIndex);
      slotLoadMatch[i] = slotWrites(slots[i], sourceIndex) & slots[i].memRead;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writes, stalls ID on hazards and
// selects EX operand forwarding. Forwarding is built only with HAZARD_FORWARDING_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_INDEX_WIDTH = 5,
  parameter int NUM_SOURCES     = 2,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_scoreboard_if.slave       bus,
  output logic [COUNTER_WIDTH-1:0] stallCycles
);

  function automatic logic [MAX_REG_INDEX_WIDTH-1:0] widenIndex(
    input logic [REG_INDEX_WIDTH-1:0] index);
    widenIndex = '0;
    widenIndex[REG_INDEX_WIDTH-1:0] = index;
  endfunction

  slotStateT [SLOT_COUNT-1:0]                         slots;
  slotStateT                                          issueSlot;
  logic [NUM_SOURCES-1:0][MAX_REG_INDEX_WIDTH-1:0]    idSource;
  logic [NUM_SOURCES-1:0][SLOT_COUNT-1:0]             idSlotMatch;
  logic [NUM_SOURCES-1:0][SLOT_COUNT-1:0]             idLoadMatch;
  logic [NUM_SOURCES-1:0]                             sourceHazard;
  logic [NUM_SOURCES*2-1:0]                           forwardSelectInt;
  logic                                               stallInt;
  logic                                               unusedMatchBits;

  // A stalled or flushed ID instruction leaves a bubble behind it in EX.
  always_comb begin
    issueSlot            = '0;
    issueSlot.valid      = bus.issueValid & ~bus.flush & ~stallInt;
    issueSlot.regWrite   = bus.issueRegWrite;
    issueSlot.memRead    = bus.issueMemRead;
    issueSlot.writeIndex = widenIndex(bus.issueWriteIndex);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots <= '0;
    end else begin
      slots[SLOT_WB]  <= slots[SLOT_MEM];
      slots[SLOT_MEM] <= slots[SLOT_EX];
      slots[SLOT_EX]  <= issueSlot;
    end
  end

  for (genvar s = 0; s < NUM_SOURCES; s++) begin : genIdSource
    assign idSource[s] = widenIndex(bus.issueSourceIndex[s*REG_INDEX_WIDTH +: REG_INDEX_WIDTH]);

    hazard_source_match idMatch (
      .sourceIndex   (idSource[s]),
      .slots         (slots),
      .slotMatch     (idSlotMatch[s]),
      .slotLoadMatch (idLoadMatch[s])
    );

`ifdef HAZARD_FORWARDING_EN
    assign sourceHazard[s] = idLoadMatch[s][SLOT_EX];
`else
    assign sourceHazard[s] = |idSlotMatch[s];
`endif
  end

  assign stallInt = ~bus.flush & bus.issueValid & (|(bus.issueSourceUsed & sourceHazard));

`ifdef HAZARD_FORWARDING_EN
  logic [NUM_SOURCES-1:0][MAX_REG_INDEX_WIDTH-1:0] exSource;
  logic [NUM_SOURCES-1:0]                          exSourceUsed;
  logic [NUM_SOURCES-1:0][SLOT_COUNT-1:0]          exSlotMatch;
  logic [NUM_SOURCES-1:0][SLOT_COUNT-1:0]          unusedExLoadMatch;

  // Source fields travel only into the EX slot; later slots need just the write side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exSource     <= '0;
      exSourceUsed <= '0;
    end else begin
      exSource     <= idSource;
      exSourceUsed <= bus.issueSourceUsed;
    end
  end

  for (genvar s = 0; s < NUM_SOURCES; s++) begin : genExSource
    hazard_source_match exMatch (
      .sourceIndex   (exSource[s]),
      .slots         (slots),
      .slotMatch     (exSlotMatch[s]),
      .slotLoadMatch (unusedExLoadMatch[s])
    );
  end

  // The younger MEM result wins over the older WB value for the same register.
  always_comb begin
    forwardSelectInt = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (slots[SLOT_EX].valid && exSourceUsed[s]) begin
        if (exSlotMatch[s][SLOT_MEM]) begin
          forwardSelectInt[s*2 +: 2] = FWD_MEM;
        end else if (exSlotMatch[s][SLOT_WB]) begin
          forwardSelectInt[s*2 +: 2] = FWD_WB;
        end else begin
          forwardSelectInt[s*2 +: 2] = FWD_NONE;
        end
      end
    end
  end

  assign unusedMatchBits = ^{idSlotMatch, idLoadMatch, exSlotMatch};
`else
  assign forwardSelectInt = '0;
  assign unusedMatchBits  = ^{idSlotMatch, idLoadMatch};
`endif

  assign bus.stall         = stallInt;
  assign bus.forwardSelect = forwardSelectInt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (stallInt && (stallCycles != '1)) begin
      stallCycles <= stallCycles + COUNTER_WIDTH'(1);
    end
  end

endmodule
